reg_wr_arb: RTL and testbench

REG_WR_ARB -- requirements
Module: reg_wr_arb

---
 rtl/reg_wr_arb.sv | 111 +++++++++++
 tb/tb_reg_wr_arb.sv | 134 +++++++++++++
 2 files changed

// File: rtl/reg_wr_arb.sv
// rtl/reg_wr_arb.sv - four-requester round-robin write arbiter with burst lock onto a shared register
module reg_wr_arb #(
    parameter int width    = 1,
    parameter int maxburst = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [3:0]         req,
    input  logic [3:0]         hold,
    input  logic [4*width-1:0] d,
    output logic [3:0]         gnt,
    output logic [width-1:0]   q,
    output logic               qvalid,
    output logic [1:0]         owner,
    output logic               locked
);

    typedef enum logic {IDLE, LOCKED} state_t;

    // Last grant index that still allows the owner to extend its burst.
    localparam logic [2:0] last_cnt = 3'(maxburst - 1);

    state_t     state;
    state_t     state_nx;
    logic [1:0] ptr;
    logic [1:0] ptr_nx;
    logic [2:0] cnt;
    logic [2:0] cnt_nx;
    logic [2:0] base_cnt;
    logic [1:0] start;
    logic [1:0] idx;
    logic [1:0] win;
    logic       win_vld;

    // Pick the winner: a locked owner that still requests keeps the grant,
    // otherwise a rotating search from ptr (idle) or owner+1 (locked owner gone).
    always_comb begin
        win     = 2'd0;
        win_vld = 1'b0;
        idx     = 2'd0;
        start   = (state == LOCKED) ? owner + 2'd1 : ptr;
        if (state == LOCKED && req[owner]) begin
            win     = owner;
            win_vld = 1'b1;
        end else begin
            for (int k = 0; k < 4; k++) begin
                idx = start + 2'(k);
                if (!win_vld && req[idx]) begin
                    win     = idx;
                    win_vld = 1'b1;
                end
            end
        end
    end

    // Grant is one-hot from the single winner index and forced off during reset.
    always_comb begin
        gnt = 4'b0000;
        if (rst_n && win_vld) begin
            gnt = 4'b0001 << win;
        end
    end

    // Next burst state: a new owner starts counting from zero; release either on
    // dropped hold or once the burst limit is reached, advancing the priority pointer.
    always_comb begin
        state_nx = IDLE;
        cnt_nx   = 3'd0;
        ptr_nx   = ptr;
        base_cnt = (state == LOCKED && win == owner) ? cnt : 3'd0;
        if (win_vld) begin
            if (maxburst > 1 && hold[win] && base_cnt < last_cnt) begin
                state_nx = LOCKED;
                cnt_nx   = base_cnt + 3'd1;
            end else begin
                ptr_nx = win + 2'd1;
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            ptr    <= 2'd0;
            cnt    <= 3'd0;
            locked <= 1'b0;
        end else begin
            state  <= state_nx;
            ptr    <= ptr_nx;
            cnt    <= cnt_nx;
            locked <= (state_nx == LOCKED);
        end
    end

    // Shared register: load the winner's data on a granted edge, pulse qvalid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q      <= '0;
            qvalid <= 1'b0;
            owner  <= 2'd0;
        end else begin
            qvalid <= win_vld;
            if (win_vld) begin
                q     <= d[win*width +: width];
                owner <= win;
            end
        end
    end

endmodule

// File: tb/tb_reg_wr_arb.sv
// tb/tb_reg_wr_arb.sv - directed self-checking bench for reg_wr_arb
module tb_reg_wr_arb;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [3:0]  hold;
    logic [15:0] d;
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic        qvalid;
    logic [1:0]  owner;
    logic        locked;

    int nvec;
    int nbad;

    reg_wr_arb #(.width(4), .maxburst(4)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .req    (req),
        .hold   (hold),
        .d      (d),
        .gnt    (gnt),
        .q      (q),
        .qvalid (qvalid),
        .owner  (owner),
        .locked (locked)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Apply req/hold just after a posedge, check at the following negedge,
    // then advance to just after the next posedge.
    task automatic step(input int n, input logic [3:0] r, input logic [3:0] h,
                        input logic [3:0] eg, input logic [3:0] eq,
                        input logic eqv, input logic elk);
        req  = r;
        hold = h;
        @(negedge clk);
        check($sformatf("s%0d gnt", n), 32'(gnt), 32'(eg));
        check($sformatf("s%0d q", n), 32'(q), 32'(eq));
        check($sformatf("s%0d qvalid", n), 32'(qvalid), 32'(eqv));
        check($sformatf("s%0d locked", n), 32'(locked), 32'(elk));
        @(posedge clk);
        #1;
    endtask

    initial begin
        nvec  = 0;
        nbad  = 0;
        rst_n = 1'b0;
        req   = 4'b1111;
        hold  = 4'b0000;
        d     = 16'hC953;
        #3;
        check("rst gnt", 32'(gnt), 32'h0);
        check("rst q", 32'(q), 32'h0);
        check("rst qvalid", 32'(qvalid), 32'h0);
        check("rst owner", 32'(owner), 32'h0);
        check("rst locked", 32'(locked), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Plain round robin, all requesting, no hold.
        step(1,  4'b1111, 4'b0000, 4'b0001, 4'h0, 1'b0, 1'b0);
        step(2,  4'b1111, 4'b0000, 4'b0010, 4'h3, 1'b1, 1'b0);
        step(3,  4'b1111, 4'b0000, 4'b0100, 4'h5, 1'b1, 1'b0);
        step(4,  4'b1111, 4'b0000, 4'b1000, 4'h9, 1'b1, 1'b0);
        step(5,  4'b1111, 4'b0000, 4'b0001, 4'hC, 1'b1, 1'b0);
        step(6,  4'b0000, 4'b0000, 4'b0000, 4'h3, 1'b1, 1'b0);
        step(7,  4'b0000, 4'b0000, 4'b0000, 4'h3, 1'b0, 1'b0);

        // Write 4'hA, then idle: q holds, qvalid drops, ptr stays at 1.
        d = 16'hC95A;
        step(8,  4'b0001, 4'b0000, 4'b0001, 4'h3, 1'b0, 1'b0);
        step(9,  4'b0000, 4'b0000, 4'b0000, 4'hA, 1'b1, 1'b0);
        step(10, 4'b0000, 4'b0000, 4'b0000, 4'hA, 1'b0, 1'b0);
        step(11, 4'b0000, 4'b0000, 4'b0000, 4'hA, 1'b0, 1'b0);
        step(12, 4'b1111, 4'b0000, 4'b0010, 4'hA, 1'b0, 1'b0);

        // ptr=2, requester 2 holds: four grants, forced release, then 0, then 2.
        step(13, 4'b0101, 4'b0100, 4'b0100, 4'h5, 1'b1, 1'b0);
        step(14, 4'b0101, 4'b0100, 4'b0100, 4'h9, 1'b1, 1'b1);
        step(15, 4'b0101, 4'b0100, 4'b0100, 4'h9, 1'b1, 1'b1);
        step(16, 4'b0101, 4'b0100, 4'b0100, 4'h9, 1'b1, 1'b1);
        step(17, 4'b0101, 4'b0100, 4'b0001, 4'h9, 1'b1, 1'b0);
        step(18, 4'b0101, 4'b0100, 4'b0100, 4'hA, 1'b1, 1'b0);
        step(19, 4'b0000, 4'b0000, 4'b0000, 4'h9, 1'b1, 1'b1);

        // Requester 1 locked, then drops: search continues from 2, no bubble.
        step(20, 4'b0010, 4'b0010, 4'b0010, 4'h9, 1'b0, 1'b0);
        step(21, 4'b0010, 4'b0010, 4'b0010, 4'h5, 1'b1, 1'b1);
        step(22, 4'b1001, 4'b0000, 4'b1000, 4'h5, 1'b1, 1'b1);
        step(23, 4'b0000, 4'b0000, 4'b0000, 4'hC, 1'b1, 1'b0);
        check("s23 owner", 32'(owner), 32'h3);

        // Pointer wrap 3 -> 0.
        step(24, 4'b0100, 4'b0000, 4'b0100, 4'hC, 1'b0, 1'b0);
        step(25, 4'b1001, 4'b0000, 4'b1000, 4'h9, 1'b1, 1'b0);
        step(26, 4'b1001, 4'b0000, 4'b0001, 4'hC, 1'b1, 1'b0);

        // Reset between edges during a burst.
        step(27, 4'b0010, 4'b0010, 4'b0010, 4'hA, 1'b1, 1'b0);
        step(28, 4'b0010, 4'b0010, 4'b0010, 4'h5, 1'b1, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid rst gnt", 32'(gnt), 32'h0);
        check("mid rst q", 32'(q), 32'h0);
        check("mid rst qvalid", 32'(qvalid), 32'h0);
        check("mid rst locked", 32'(locked), 32'h0);
        check("mid rst owner", 32'(owner), 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(29, 4'b1111, 4'b0000, 4'b0001, 4'h0, 1'b0, 1'b0);
        step(30, 4'b0000, 4'b0000, 4'b0000, 4'hA, 1'b1, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
